moving_integrator_decoder: RTL and testbench

MOVING_INTEGRATOR_DECODER -- requirements
Module: moving_integrator_decoder

---
 rtl/moving_integrator_decoder.sv | 104 ++++++++++
 tb/tb_moving_integrator_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/moving_integrator_decoder.sv
// moving_integrator_decoder: recovers x[n] from a 32-sample running sum, x[n] = s[n] - s[n-1] + x[n-32].
// Build option: define MOVING_DECODER_SAT_EN to saturate out-of-range results instead of wrapping them.
module moving_integrator_decoder #(
   parameter int K = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic signed [21:0] s,
   output logic signed [15:0] x_out,
   output logic               x_valid,
   output logic               primed,
   output logic               ovf
);

   typedef enum logic {PRIME, RUN} state_t;

   localparam logic signed [23:0] MAX16 = 24'sd32767;
   localparam logic signed [23:0] MIN16 = -24'sd32768;

   state_t             state;
   logic [5:0]         count;
   logic signed [21:0] s_reg;
   logic signed [21:0] s_prev;
   logic               v1;
   logic signed [15:0] dly [K];
   logic signed [23:0] d;
   logic signed [15:0] x_next;
   logic               ovf_now;

   // Stage 1: capture the running sum and its predecessor; an in-flight sample dies with reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_reg  <= '0;
         s_prev <= '0;
         v1     <= 1'b0;
      end else begin
         // NOTE: non-blocking so s_prev takes the old s_reg, not the value written this edge.
         v1 <= enable;
         if (enable) begin
            s_reg  <= s;
            s_prev <= s_reg;
         end
      end
   end

   // 24 bits hold the 22-bit difference plus the 16-bit delayed term without overflow.
   always_comb begin
      // NOTE: defaults first so every path assigns x_next and no latch is inferred.
      d       = 24'(s_reg) - 24'(s_prev) + 24'(dly[K-1]);
      ovf_now = (d > MAX16) || (d < MIN16);
      x_next  = d[15:0];
`ifdef MOVING_DECODER_SAT_EN
      if (d > MAX16)
         x_next = 16'sh7fff;
      else if (d < MIN16)
         x_next = 16'sh8000;
`endif
   end

   // Stage 2: register the result and push it into the delay line that supplies x[n-32].
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_out   <= '0;
         x_valid <= 1'b0;
         ovf     <= 1'b0;
         // NOTE: the delay line is reset because decoding relies on x[n-32]=0 for the first window.
         for (int i = 0; i < K; i++)
            dly[i] <= '0;
      end else begin
         x_valid <= v1;
         if (v1) begin
            x_out  <= x_next;
            dly[0] <= x_next;
            for (int i = 1; i < K; i++)
               dly[i] <= dly[i-1];
            if (ovf_now)
               ovf <= 1'b1;
         end
      end
   end

   // Priming tracker: primed rises together with the 32nd x_valid and the counter parks at 32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= PRIME;
         count  <= '0;
         primed <= 1'b0;
      end else if (v1) begin
         case (state)
            PRIME: begin
               count <= count + 6'd1;
               if (count == 6'(K - 1)) begin
                  state  <= RUN;
                  primed <= 1'b1;
               end
            end
            RUN: count <= 6'(K);
            default: state <= PRIME;
         endcase
      end
   end

endmodule

// File: tb/tb_moving_integrator_decoder.sv
// Bench for moving_integrator_decoder: vector tables feed a scoreboard checked on the falling edge.
module tb_moving_integrator_decoder;

   typedef struct {
      logic               en;
      logic signed [21:0] s;
      logic signed [15:0] exp_x;
      logic               exp_ovf;
   } vec_t;

   typedef struct {
      logic signed [15:0] x;
      logic               ovf;
      int                 cyc;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               enable;
   logic signed [21:0] s;
   logic signed [15:0] x_out;
   logic               x_valid;
   logic               primed;
   logic               ovf;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   n_valid  = 0;
   exp_t sb[$];
   vec_t vecs[$];
   exp_t mon_e;

   moving_integrator_decoder #(.K(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .s       (s),
      .x_out   (x_out),
      .x_valid (x_valid),
      .primed  (primed),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Falling-edge monitor: every x_valid must match the oldest expectation, on the expected cycle.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (x_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("spurious_valid", x_valid, 0);
            end else begin
               mon_e = sb.pop_front();
               n_valid++;
               check("x_out", x_out, mon_e.x);
               check("latency", cyc, mon_e.cyc);
               check("ovf", ovf, mon_e.ovf);
               check("primed", primed, (n_valid >= 32));
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            check("missing_valid", x_valid, 1);
            void'(sb.pop_front());
         end
      end
   end

   // Drive one sample just after a rising edge; its output is due after the following edge.
   task automatic apply(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      enable = v.en;
      s      = v.s;
      if (v.en) begin
         e.x   = v.exp_x;
         e.ovf = v.exp_ovf;
         e.cyc = cyc + 2;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         enable = 1'b0;
      end
   endtask

   task automatic run_vecs(input int count);
      for (int i = 0; i < count && i < vecs.size(); i++)
         apply(vecs[i]);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b0;
      sb.delete();
      n_valid = 0;
      #1;
      check("rst_x_out", x_out, 0);
      check("rst_x_valid", x_valid, 0);
      check("rst_primed", primed, 0);
      check("rst_ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain();
      idle(4);
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic push_vec(input logic en, input int sv, input int xv, input logic ov);
      vec_t v;
      v.en      = en;
      v.s       = 22'(sv);
      v.exp_x   = 16'(xv);
      v.exp_ovf = ov;
      vecs.push_back(v);
   endtask

   // Ramp to 3200 then hold: every reconstructed sample is 100.
   task automatic build_ramp();
      vecs.delete();
      for (int n = 0; n < 40; n++)
         push_vec(1'b1, (n < 32) ? 100 * (n + 1) : 3200, 100, 1'b0);
   endtask

   initial begin
      logic signed [15:0] wrap_x;
`ifdef MOVING_DECODER_SAT_EN
      wrap_x = 16'sh7fff;
`else
      wrap_x = -16'sd25536;
`endif
      reset  = 1'b0;
      enable = 1'b0;
      s      = '0;
      #3;
      do_reset();

      // Constant stream after a ramp-up.
      build_ramp();
      run_vecs(40);
      drain();
      check("ramp_primed_end", primed, 1);
      check("ramp_ovf_end", ovf, 0);

      // Asynchronous reset between edges while sample 20 sits in stage 1.
      do_reset();
      build_ramp();
      run_vecs(21);
      @(posedge clk);
      #3;
      reset  = 1'b1;
      enable = 1'b0;
      sb.delete();
      n_valid = 0;
      #1;
      check("async_x_out", x_out, 0);
      check("async_x_valid", x_valid, 0);
      check("async_primed", primed, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(3);
      run_vecs(40);
      drain();

      // Impulse: x[0]=1000 must be cancelled when it leaves the window at n=32.
      do_reset();
      vecs.delete();
      for (int n = 0; n < 40; n++)
         push_vec(1'b1, (n < 32) ? 1000 : 0, (n == 0) ? 1000 : 0, 1'b0);
      run_vecs(40);
      drain();

      // Alternating enable with junk on idle cycles; primed only after 32 outputs.
      do_reset();
      vecs.delete();
      for (int n = 0; n < 40; n++) begin
         push_vec(1'b1, (n < 32) ? 100 * (n + 1) : 3200, 100, 1'b0);
         push_vec(1'b0, 12345 + n, 0, 1'b0);
      end
      run_vecs(80);
      drain();
      check("alt_primed_end", primed, 1);

      // Overflow: jump of 40000 exceeds 16 bits; ovf stays set afterwards.
      do_reset();
      vecs.delete();
      push_vec(1'b1, 0, 0, 1'b0);
      push_vec(1'b1, 40000, wrap_x, 1'b1);
      push_vec(1'b1, 40000, 0, 1'b1);
      push_vec(1'b1, 40000, 0, 1'b1);
      run_vecs(4);
      drain();
      check("ovf_sticky", ovf, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
